// File: rtl/press_pkg.sv
// ============================================================================
// Module  : press_pkg
// Purpose : State encoding and counter sizing shared by press_classifier.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package press_pkg;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_press1 = 3'd1;
    localparam logic [2:0] c_st_gap    = 3'd2;
    localparam logic [2:0] c_st_press2 = 3'd3;
    localparam logic [2:0] c_st_held   = 3'd4;

    function automatic int cnt_width(input int long_cyc, input int gap_cyc);
        int max_cyc;
        max_cyc = (long_cyc > gap_cyc) ? long_cyc : gap_cyc;
        return $clog2(max_cyc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/press_classifier.sv
// ============================================================================
// Module  : press_classifier
// Purpose : Classifies a debounced button level into short, long and double
//           press pulses.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module press_classifier
    import press_pkg::*;
#(
    parameter int LONG_CYC = 50000000,
    parameter int GAP_CYC  = 12500000
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);

    localparam int                 c_cnt_w     = cnt_width(LONG_CYC, GAP_CYC);
    localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_in_d;
    logic               r_short;
    logic               r_long;
    logic               r_double;
    logic               r_busy;

    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_rise;
    logic               w_fall;
    logic               w_short_nxt;
    logic               w_long_nxt;
    logic               w_double_nxt;

    assign w_rise = in & ~r_in_d;
    assign w_fall = ~in & r_in_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_rise) w_state_nxt = c_st_press1;
            end
            c_st_press1: begin
                if (w_fall) begin
                    w_state_nxt = c_st_gap;
                end else if (in && (r_cnt == c_long_last)) begin
                    w_state_nxt = c_st_held;
                    w_long_nxt  = 1'b1;
                end
            end
            c_st_gap: begin
                // A re-press wins over gap expiry on the same edge.
                if (w_rise) begin
                    w_state_nxt = c_st_press2;
                end else if (!in && (r_cnt == c_gap_last)) begin
                    w_state_nxt = c_st_idle;
                    w_short_nxt = 1'b1;
                end
            end
            c_st_press2: begin
                if (w_fall) begin
                    w_state_nxt  = c_st_idle;
                    w_double_nxt = 1'b1;
                end else if (in && (r_cnt == c_long_last)) begin
                    w_state_nxt = c_st_held;
                    w_long_nxt  = 1'b1;
                end
            end
            c_st_held: begin
                if (w_fall) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Counter restarts on any state change and saturates rather than wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // in_d resets high so a button held through reset release is not a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_in_d   <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_in_d   <= in;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_double <= w_double_nxt;
            r_busy   <= (w_state_nxt != c_st_idle);
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_press_classifier.sv
// ============================================================================
// Module  : tb_press_classifier
// Purpose : Randomized scoreboard bench for press_classifier.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int c_k_short  = 0;
    localparam int c_k_long   = 1;
    localparam int c_k_double = 2;

    logic clock = 1'b0;
    logic reset;
    logic in;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    always #5 clock = ~clock;

    press_classifier #(.LONG_CYC(LONG), .GAP_CYC(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .busy         (busy)
    );

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t  exp_q[$];
    bit   busy_exp [0:16383];
    logic lv [0:2047];
    int   n = 0;
    int   edge_n = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    always @(posedge clock) edge_n <= edge_n + 1;

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clock) begin
        int  k;
        int  kind;
        ev_t ev;
        k = int'(short_press === 1'b1) + int'(long_press === 1'b1) + int'(double_press === 1'b1);
        kind = (short_press === 1'b1) ? c_k_short : (long_press === 1'b1) ? c_k_long : c_k_double;
        if (k > 1) begin
            vectors++;
            miscompares++;
            $display("FAIL onehot edge %0d: %0d pulses high, want at most 1", edge_n, k);
        end else if (k == 1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse edge %0d: kind %0d, want none", edge_n, kind);
            end else begin
                ev = exp_q.pop_front();
                if (ev.kind != kind || ev.at != edge_n) begin
                    miscompares++;
                    $display("FAIL pulse: got kind %0d at edge %0d, want kind %0d at edge %0d",
                             kind, edge_n, ev.kind, ev.at);
                end
            end
        end
        if (chk_en && edge_n < 16384) begin
            vectors++;
            if (busy !== busy_exp[edge_n]) begin
                miscompares++;
                $display("FAIL busy edge %0d: got %b want %b", edge_n, busy, busy_exp[edge_n]);
            end
        end
    end

    task automatic add_seg(input logic lvl, input int len);
        for (int i = 0; i < len; i++) begin
            lv[n] = lvl;
            n++;
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t ev;
        ev.kind = kind;
        ev.at   = at;
        exp_q.push_back(ev);
    endtask

    // Reference model works on the list of presses (rise/fall sample indices).
    task automatic run_phase(input logic prev_in);
        int   rr[$];
        int   ff[$];
        int   base, i, r, f, r2, f2, e;
        logic p;
        @(negedge clock);
        base = edge_n + 1;
        p = prev_in;
        for (int t = 0; t < n; t++) begin
            if (lv[t] && !p) rr.push_back(t);
            if (!lv[t] && p && rr.size() > ff.size()) ff.push_back(t);
            p = lv[t];
        end
        if (ff.size() < rr.size()) ff.push_back(n);
        i = 0;
        while (i < rr.size()) begin
            r = rr[i];
            f = ff[i];
            if (f - r > LONG) begin
                push_ev(c_k_long, base + r + LONG);
                e = f;
                i++;
            end else if (i + 1 < rr.size() && rr[i+1] - f <= GAP) begin
                r2 = rr[i+1];
                f2 = ff[i+1];
                if (f2 - r2 > LONG) push_ev(c_k_long, base + r2 + LONG);
                else                push_ev(c_k_double, base + f2);
                e = f2;
                i += 2;
            end else begin
                push_ev(c_k_short, base + f + GAP);
                e = f + GAP;
                i++;
            end
            for (int t = r; t < e; t++) if (base + t < 16384) busy_exp[base + t] = 1'b1;
        end
        for (int t = 0; t < n; t++) begin
            in = lv[t];
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulse: %0d expected pulses outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        n = 0;
    endtask

    task automatic check_quiet(input string tag);
        vectors++;
        if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s: outputs s/l/d/b = %b, want 0000", tag,
                     {short_press, long_press, double_press, busy});
        end
    endtask

    task automatic rand_seg(input logic lvl);
        int c;
        c = $urandom_range(0, 4);
        if (lvl) begin
            case (c)
                0:       add_seg(1'b1, $urandom_range(1, 4));
                1:       add_seg(1'b1, $urandom_range(5, 19));
                2:       add_seg(1'b1, LONG);
                3:       add_seg(1'b1, LONG + 1);
                default: add_seg(1'b1, $urandom_range(22, 30));
            endcase
        end else begin
            case (c)
                0:       add_seg(1'b0, $urandom_range(1, 3));
                1:       add_seg(1'b0, GAP - 1);
                2:       add_seg(1'b0, GAP);
                3:       add_seg(1'b0, GAP + 1);
                default: add_seg(1'b0, $urandom_range(12, 15));
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        in    = 1'b0;
        #2;
        check_quiet("reset_async");
        repeat (3) @(negedge clock);
        check_quiet("reset_hold");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_quiet("post_reset");
        chk_en = 1'b1;

        // Short tap, long hold, double tap, slow second tap
        add_seg(1'b0, 3); add_seg(1'b1, 5);  add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 30); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 3); add_seg(1'b0, 4);  add_seg(1'b1, 3); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 3); add_seg(1'b0, 12); add_seg(1'b1, 3); add_seg(1'b0, 30); run_phase(in);
        // Long on second tap, one-cycle gap, gap and hold boundaries
        add_seg(1'b1, 3); add_seg(1'b0, 2);  add_seg(1'b1, 25); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 3); add_seg(1'b0, 1);  add_seg(1'b1, 3); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 2); add_seg(1'b0, GAP);     add_seg(1'b1, 2); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 2); add_seg(1'b0, GAP + 1); add_seg(1'b1, 2); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, LONG);     add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, LONG + 1); add_seg(1'b0, 30); run_phase(in);
        add_seg(1'b1, 1); add_seg(1'b0, 30); run_phase(in);

        // Reset mid-PRESS1 with the button held through release
        chk_en = 1'b0;
        in = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check_quiet("midop_reset_async");
        repeat (3) @(negedge clock);
        check_quiet("midop_reset_hold");
        reset = 1'b1;
        chk_en = 1'b1;
        add_seg(1'b1, 8); add_seg(1'b0, 3); add_seg(1'b1, 4); add_seg(1'b0, 30);
        run_phase(1'b1);

        for (int ph = 0; ph < 20; ph++) begin
            for (int s = 0; s < 6; s++) begin
                rand_seg(1'b1);
                rand_seg(1'b0);
            end
            add_seg(1'b0, 30);
            run_phase(in);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_CYC, default 50000000, giving the hold duration in clock cycles that qualifies as a long press.
REQ-002 The block SHALL have parameter GAP_CYC, default 12500000, giving the maximum released gap in clock cycles between two taps of a double press.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port in, input, 1 bit, the debounced button level, synchronous to clock (1 = pressed).
REQ-006 The block SHALL have port short_press, output, 1 bit, a one-cycle pulse for a single short tap.
REQ-007 The block SHALL have port long_press, output, 1 bit, a one-cycle pulse when a hold reaches LONG_CYC.
REQ-008 The block SHALL have port double_press, output, 1 bit, a one-cycle pulse when the second tap of a double press is released.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL hold register in_d, the value of in at the previous clock edge; a rise is in=1 with in_d=0, a fall is in=0 with in_d=1.
REQ-011 The block SHALL implement the states IDLE, PRESS1, GAP, PRESS2 and HELD, with one counter cnt that is cleared on every state change.
REQ-012 In IDLE, a rise SHALL move the block to PRESS1.
REQ-013 In PRESS1, a fall before cnt reaches LONG_CYC-1 SHALL move the block to GAP; if cnt reaches LONG_CYC-1 while in=1, the block SHALL pulse long_press and move to HELD.
REQ-014 In GAP, a rise SHALL move the block to PRESS2; if cnt reaches GAP_CYC-1 with in=0, the block SHALL pulse short_press and move to IDLE.
REQ-015 In PRESS2, a fall SHALL pulse double_press and move to IDLE; if cnt reaches LONG_CYC-1 while in=1, the block SHALL pulse long_press and move to HELD, and the first tap SHALL be discarded.
REQ-016 In HELD, the block SHALL emit no pulse and SHALL move to IDLE on a fall.
REQ-017 All outputs SHALL be registered; each pulse SHALL be high for exactly the one cycle after the edge that detects its condition.
REQ-018 At most one of the three pulse outputs SHALL be high in any cycle.
REQ-019 cnt SHALL be $clog2(max(LONG_CYC,GAP_CYC)) bits wide, SHALL increment by 1 per cycle, and SHALL never wrap.
REQ-020 LONG_CYC and GAP_CYC SHALL each be at least 2; smaller values are unsupported.
REQ-021 A release and a re-press on consecutive cycles SHALL be honoured: GAP lasting one cycle, then a rise, still enters PRESS2.

Reset
REQ-022 While reset=0, the block SHALL force the state to IDLE, cnt to 0, and short_press, long_press, double_press and busy to 0, independent of clock.
REQ-023 While reset=0, in_d SHALL be forced to 1, so that a button held through reset release is ignored until it has been released.
REQ-024 When reset is asserted mid-operation, the block SHALL abandon any partial classification and emit no pulse.

Structure
REQ-025 The state encoding localparams SHALL be placed in the shared package press_pkg, for use by the bench and any display logic.
REQ-026 The block SHALL be a single module with edge detection inline and no sub-module.
REQ-027 The block SHALL sit directly downstream of the debounce stage, with its in port driven by the debouncer out.

Verification (LONG_CYC=20, GAP_CYC=10)
REQ-028 Short tap: in high 5 cycles then low -> short_press single pulse 10 cycles after the fall; no other pulse; busy drops with the pulse.
REQ-029 Long hold: in high 30 cycles -> long_press pulse 20 cycles after the rise is registered; nothing on the release; busy low after the fall.
REQ-030 Double tap: high 3, low 4, high 3, low -> double_press pulse one cycle after the second fall; no short_press.
REQ-031 Slow second tap: high 3, low 12, high 3, low -> short_press at gap cycle 10, then the second tap handled as a fresh PRESS1 ending in short_press.
REQ-032 Reset mid-PRESS1 with in held high through reset release -> all outputs 0, no pulse until in falls and rises again.
REQ-033 Long hold on second tap: high 3, low 2, high 25 -> single long_press pulse, no short_press or double_press.
